// File: rtl/mem_port_arbiter_if.sv
// Bundles the requester and memory-side signals of mem_port_arbiter.
//   master : arbiter view. Takes in the fetch/data requests and the memory
//            responses. Drives the grants, the responses and the memory request.
//   slave  : environment view (core requesters plus memory model).
// Signal names match the original flat port list.
interface mem_port_arbiter_if;
  logic        i_ins_req;
  logic [31:0] i_ins_address;
  logic        o_ins_grant;
  logic        o_ins_valid;
  logic [31:0] o_ins_data;
  logic        o_ins_error;

  logic        i_dat_req;
  logic        i_dat_rw;
  logic [31:0] i_dat_address;
  logic [31:0] i_dat_wdata;
  logic [3:0]  i_dat_strobe;
  logic        o_dat_grant;
  logic        o_dat_valid;
  logic [31:0] o_dat_rdata;
  logic        o_dat_error;

  logic        o_mem_req;
  logic        o_mem_rw;
  logic [31:0] o_mem_address;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_strobe;
  logic        i_mem_ack;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  modport master (
    input  i_ins_req, i_ins_address,
    output o_ins_grant, o_ins_valid, o_ins_data, o_ins_error,
    input  i_dat_req, i_dat_rw, i_dat_address, i_dat_wdata, i_dat_strobe,
    output o_dat_grant, o_dat_valid, o_dat_rdata, o_dat_error,
    output o_mem_req, o_mem_rw, o_mem_address, o_mem_wdata, o_mem_strobe,
    input  i_mem_ack, i_mem_rvalid, i_mem_rdata
  );

  modport slave (
    output i_ins_req, i_ins_address,
    input  o_ins_grant, o_ins_valid, o_ins_data, o_ins_error,
    output i_dat_req, i_dat_rw, i_dat_address, i_dat_wdata, i_dat_strobe,
    input  o_dat_grant, o_dat_valid, o_dat_rdata, o_dat_error,
    input  o_mem_req, o_mem_rw, o_mem_address, o_mem_wdata, o_mem_strobe,
    output i_mem_ack, i_mem_rvalid, i_mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-ported memory between the
// instruction-fetch requester and the data load/store requester.
// It handles one transaction at a time: IDLE -> ISSUE (req/ack) -> WAIT (rvalid).
// A transaction that the memory does not finish within TIMEOUT cycles is
// aborted, and the owner gets an error response.
// Ports:
//   i_clock, i_reset : clock, synchronous active-high reset
//   bus              : requester and memory handshakes (mem_port_arbiter_if.master)
//   o_timeout_flag   : sticky, set by any timeout since reset
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               i_clock,
  input  logic               i_reset,
  mem_port_arbiter_if.master bus,
  output logic               o_timeout_flag
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        owner_dat_q, owner_dat_d;
  logic        last_dat_q, last_dat_d;
  logic        ins_grant_q, ins_grant_d;
  logic        ins_valid_q, ins_valid_d;
  logic        ins_error_q, ins_error_d;
  logic [31:0] ins_data_q, ins_data_d;
  logic        dat_grant_q, dat_grant_d;
  logic        dat_valid_q, dat_valid_d;
  logic        dat_error_q, dat_error_d;
  logic [31:0] dat_rdata_q, dat_rdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_rw_q, mem_rw_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_strobe_q, mem_strobe_d;
  logic        timeout_q, timeout_d;

  logic        pick_dat;
  logic        done;

  // On a tie, the data side wins unless it was the last one served.
  assign pick_dat = bus.i_dat_req && (!bus.i_ins_req || !last_dat_q);
  // Only rvalid in WAIT completes a transaction. Completion beats the timeout.
  assign done     = (state_q == ST_WAIT) && bus.i_mem_rvalid;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_dat_d   = owner_dat_q;
    last_dat_d    = last_dat_q;
    ins_grant_d   = 1'b0;
    ins_valid_d   = 1'b0;
    ins_error_d   = 1'b0;
    ins_data_d    = ins_data_q;
    dat_grant_d   = 1'b0;
    dat_valid_d   = 1'b0;
    dat_error_d   = 1'b0;
    dat_rdata_d   = dat_rdata_q;
    mem_req_d     = mem_req_q;
    mem_rw_d      = mem_rw_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_strobe_d  = mem_strobe_q;
    timeout_d     = timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_ins_req || bus.i_dat_req) begin
          owner_dat_d = pick_dat;
          last_dat_d  = pick_dat;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          state_d     = ST_ISSUE;
          if (pick_dat) begin
            dat_grant_d   = 1'b1;
            mem_rw_d      = bus.i_dat_rw;
            mem_address_d = bus.i_dat_address;
            mem_wdata_d   = bus.i_dat_wdata;
            mem_strobe_d  = bus.i_dat_strobe;
          end else begin
            ins_grant_d   = 1'b1;
            mem_rw_d      = 1'b0;
            mem_address_d = bus.i_ins_address;
            mem_wdata_d   = '0;
            mem_strobe_d  = '1;
          end
        end
      end
      ST_ISSUE, ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (done) begin
          state_d = ST_IDLE;
          if (owner_dat_q) begin
            dat_valid_d = 1'b1;
            if (!mem_rw_q) dat_rdata_d = bus.i_mem_rdata;
          end else begin
            ins_valid_d = 1'b1;
            ins_data_d  = bus.i_mem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          timeout_d = 1'b1;
          if (owner_dat_q) begin
            dat_valid_d = 1'b1;
            dat_error_d = 1'b1;
          end else begin
            ins_valid_d = 1'b1;
            ins_error_d = 1'b1;
          end
        end else if ((state_q == ST_ISSUE) && bus.i_mem_ack) begin
          state_d   = ST_WAIT;
          mem_req_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      owner_dat_q   <= 1'b0;
      last_dat_q    <= 1'b0;
      ins_grant_q   <= 1'b0;
      ins_valid_q   <= 1'b0;
      ins_error_q   <= 1'b0;
      ins_data_q    <= '0;
      dat_grant_q   <= 1'b0;
      dat_valid_q   <= 1'b0;
      dat_error_q   <= 1'b0;
      dat_rdata_q   <= '0;
      mem_req_q     <= 1'b0;
      mem_rw_q      <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_strobe_q  <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_dat_q   <= owner_dat_d;
      last_dat_q    <= last_dat_d;
      ins_grant_q   <= ins_grant_d;
      ins_valid_q   <= ins_valid_d;
      ins_error_q   <= ins_error_d;
      ins_data_q    <= ins_data_d;
      dat_grant_q   <= dat_grant_d;
      dat_valid_q   <= dat_valid_d;
      dat_error_q   <= dat_error_d;
      dat_rdata_q   <= dat_rdata_d;
      mem_req_q     <= mem_req_d;
      mem_rw_q      <= mem_rw_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_strobe_q  <= mem_strobe_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.o_ins_grant   = ins_grant_q;
  assign bus.o_ins_valid   = ins_valid_q;
  assign bus.o_ins_error   = ins_error_q;
  assign bus.o_ins_data    = ins_data_q;
  assign bus.o_dat_grant   = dat_grant_q;
  assign bus.o_dat_valid   = dat_valid_q;
  assign bus.o_dat_error   = dat_error_q;
  assign bus.o_dat_rdata   = dat_rdata_q;
  assign bus.o_mem_req     = mem_req_q;
  assign bus.o_mem_rw      = mem_rw_q;
  assign bus.o_mem_address = mem_address_q;
  assign bus.o_mem_wdata   = mem_wdata_q;
  assign bus.o_mem_strobe  = mem_strobe_q;
  assign o_timeout_flag    = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (TIMEOUT = 8), driving the bus by hand.
// Responses that are expected are queued as each memory response or timeout is
// set up. A monitor pops the queue on every valid pulse and compares the result.
module tb_mem_port_arbiter;
  typedef struct packed {
    logic        dat;
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        timeout_flag;
  int unsigned checks = 0;
  int unsigned failures = 0;
  resp_t       exp_q[$];
  logic [31:0] m_ins_data;
  logic [31:0] m_dat_rdata;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(8)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .bus            (bus),
    .o_timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic resp_t mk(input logic dat, input logic [31:0] data, input logic err);
    return {dat, data, err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {bus.o_ins_grant, bus.o_ins_valid, bus.o_ins_error, bus.o_dat_grant,
                          bus.o_dat_valid, bus.o_dat_error, bus.o_mem_req, bus.o_mem_rw,
                          timeout_flag, bus.o_mem_strobe}, 13'd0);
    check({tag, "_bus"}, {bus.o_mem_address, bus.o_mem_wdata, bus.o_ins_data, bus.o_dat_rdata}, 128'd0);
  endtask

  task automatic fetch_zw(input logic [31:0] addr, input logic [31:0] data);
    bus.i_ins_req = 1'b1;
    bus.i_ins_address = addr;
    tick();
    check("fz_grant", {bus.o_ins_grant, bus.o_dat_grant, bus.o_mem_req}, 3'b101);
    check("fz_addr", bus.o_mem_address, addr);
    bus.i_ins_req = 1'b0;
    bus.i_mem_ack = 1'b1;
    tick();
    bus.i_mem_ack = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata = data;
    exp_q.push_back(mk(1'b0, data, 1'b0));
    m_ins_data = data;
    tick();
    bus.i_mem_rvalid = 1'b0;
    check("fz_valid", {bus.o_ins_valid, bus.o_ins_error}, 2'b10);
  endtask

  // Response monitor
  always @(posedge clk) begin
    resp_t e;
    #1;
    if (!rst && (bus.o_ins_valid || bus.o_dat_valid)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {bus.o_dat_valid, bus.o_ins_valid}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check("resp_owner", {bus.o_dat_valid, bus.o_ins_valid}, {e.dat, ~e.dat});
        check("resp_data", e.dat ? bus.o_dat_rdata : bus.o_ins_data, e.data);
        check("resp_error", e.dat ? bus.o_dat_error : bus.o_ins_error, e.err);
      end
    end else if (!rst && (bus.o_ins_error || bus.o_dat_error)) begin
      check("error_without_valid", {bus.o_dat_error, bus.o_ins_error}, 2'b00);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_dat;
    rst = 1'b1;
    bus.i_ins_req = 1'b0;
    bus.i_ins_address = '0;
    bus.i_dat_req = 1'b0;
    bus.i_dat_rw = 1'b0;
    bus.i_dat_address = '0;
    bus.i_dat_wdata = '0;
    bus.i_dat_strobe = '0;
    bus.i_mem_ack = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata = '0;
    m_ins_data = '0;
    m_dat_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset");

    // Single fetch, zero-wait memory
    bus.i_ins_req = 1'b1;
    bus.i_ins_address = 32'h0000_0010;
    tick();
    check("f1_grant", {bus.o_ins_grant, bus.o_dat_grant, bus.o_mem_req}, 3'b101);
    check("f1_payload", {bus.o_mem_rw, bus.o_mem_strobe, bus.o_mem_address, bus.o_mem_wdata},
          {1'b0, 4'b1111, 32'h0000_0010, 32'h0});
    bus.i_ins_req = 1'b0;
    bus.i_mem_ack = 1'b1;
    tick();
    check("f1_after_ack", {bus.o_ins_grant, bus.o_mem_req, bus.o_ins_valid}, 3'b000);
    bus.i_mem_ack = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata = 32'hDEAD_BEEF;
    exp_q.push_back(mk(1'b0, 32'hDEAD_BEEF, 1'b0));
    m_ins_data = 32'hDEAD_BEEF;
    tick();
    bus.i_mem_rvalid = 1'b0;
    check("f1_valid", {bus.o_ins_valid, bus.o_ins_error, bus.o_ins_data}, {2'b10, 32'hDEAD_BEEF});
    tick();
    check("f1_pulse", bus.o_ins_valid, 1'b0);

    // Both requesting continuously: data, ins, data, ins
    bus.i_ins_req = 1'b1;
    bus.i_ins_address = 32'h20;
    bus.i_dat_req = 1'b1;
    bus.i_dat_rw = 1'b0;
    bus.i_dat_address = 32'h200;
    bus.i_dat_strobe = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      exp_dat = (i % 2 == 0);
      tick();
      check("alt_grant", {bus.o_dat_grant, bus.o_ins_grant}, {exp_dat, ~exp_dat});
      check("alt_addr", bus.o_mem_address, exp_dat ? 32'h200 : 32'h20);
      bus.i_mem_ack = 1'b1;
      tick();
      check("alt_no_regrant", {bus.o_dat_grant, bus.o_ins_grant}, 2'b00);
      bus.i_mem_ack = 1'b0;
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata = 32'hA000_0000 + 32'(i);
      exp_q.push_back(mk(exp_dat, 32'hA000_0000 + 32'(i), 1'b0));
      if (exp_dat) m_dat_rdata = 32'hA000_0000 + 32'(i);
      else m_ins_data = 32'hA000_0000 + 32'(i);
      tick();
      bus.i_mem_rvalid = 1'b0;
    end
    bus.i_ins_req = 1'b0;
    bus.i_dat_req = 1'b0;
    tick();

    // Data write with ack delayed by 4 cycles
    bus.i_dat_req = 1'b1;
    bus.i_dat_rw = 1'b1;
    bus.i_dat_address = 32'h100;
    bus.i_dat_wdata = 32'h1234_5678;
    bus.i_dat_strobe = 4'b0011;
    tick();
    check("wr_grant", {bus.o_dat_grant, bus.o_ins_grant, bus.o_mem_req}, 3'b101);
    bus.i_dat_req = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check("wr_hold", {bus.o_mem_req, bus.o_mem_rw, bus.o_mem_strobe, bus.o_mem_address, bus.o_mem_wdata},
            {1'b1, 1'b1, 4'b0011, 32'h100, 32'h1234_5678});
      if (j < 3) tick();
    end
    bus.i_mem_ack = 1'b1;
    tick();
    check("wr_req_drop", bus.o_mem_req, 1'b0);
    bus.i_mem_ack = 1'b0;
    tick();
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata = 32'hFFFF_FFFF;
    exp_q.push_back(mk(1'b1, m_dat_rdata, 1'b0));
    tick();
    bus.i_mem_rvalid = 1'b0;
    check("wr_valid", {bus.o_dat_valid, bus.o_dat_error, bus.o_dat_rdata}, {2'b10, m_dat_rdata});

    // Timeout: memory never acknowledges
    bus.i_dat_req = 1'b1;
    bus.i_dat_rw = 1'b0;
    bus.i_dat_address = 32'h300;
    tick();
    check("to_grant", {bus.o_dat_grant, bus.o_mem_req, timeout_flag}, 3'b110);
    exp_q.push_back(mk(1'b1, m_dat_rdata, 1'b1));
    bus.i_dat_req = 1'b0;
    for (int j = 1; j < 8; j++) begin
      tick();
      check("to_waiting", {bus.o_dat_valid, bus.o_mem_req}, 2'b01);
    end
    tick();
    check("to_abort", {bus.o_dat_valid, bus.o_dat_error, bus.o_mem_req, timeout_flag}, 4'b1101);
    tick();
    check("to_sticky", {bus.o_dat_valid, bus.o_dat_error, timeout_flag}, 3'b001);
    fetch_zw(32'h40, 32'hCAFE_F00D);
    check("to_sticky2", timeout_flag, 1'b1);

    // Stray rvalid in IDLE and ISSUE, then ack+rvalid together
    bus.i_mem_rvalid = 1'b1;
    tick();
    check("stray_idle", {bus.o_ins_valid, bus.o_dat_valid, bus.o_mem_req}, 3'b000);
    bus.i_mem_rvalid = 1'b0;
    bus.i_ins_req = 1'b1;
    bus.i_ins_address = 32'h50;
    tick();
    check("stray_grant", bus.o_ins_grant, 1'b1);
    bus.i_ins_req = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    tick();
    check("stray_issue", {bus.o_ins_valid, bus.o_mem_req}, 2'b01);
    bus.i_mem_ack = 1'b1;
    tick();
    check("ack_rvalid", {bus.o_ins_valid, bus.o_mem_req}, 2'b00);
    bus.i_mem_ack = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    tick();
    check("wait_idle", bus.o_ins_valid, 1'b0);
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata = 32'h5555_AAAA;
    exp_q.push_back(mk(1'b0, 32'h5555_AAAA, 1'b0));
    m_ins_data = 32'h5555_AAAA;
    tick();
    bus.i_mem_rvalid = 1'b0;
    check("late_valid", {bus.o_ins_valid, bus.o_ins_data}, {1'b1, 32'h5555_AAAA});

    // Reset during WAIT after a data grant
    bus.i_dat_req = 1'b1;
    bus.i_dat_address = 32'h600;
    tick();
    check("rw_grant", bus.o_dat_grant, 1'b1);
    bus.i_dat_req = 1'b0;
    bus.i_mem_ack = 1'b1;
    tick();
    bus.i_mem_ack = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_all_zero("reset_mid");
    rst = 1'b0;
    m_ins_data = '0;
    m_dat_rdata = '0;
    bus.i_ins_req = 1'b1;
    bus.i_ins_address = 32'h70;
    bus.i_dat_req = 1'b1;
    bus.i_dat_address = 32'h700;
    tick();
    check("post_reset_tie", {bus.o_dat_grant, bus.o_ins_grant}, 2'b10);
    bus.i_ins_req = 1'b0;
    bus.i_dat_req = 1'b0;
    bus.i_mem_ack = 1'b1;
    tick();
    bus.i_mem_ack = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata = 32'h7777_0000;
    exp_q.push_back(mk(1'b1, 32'h7777_0000, 1'b0));
    m_dat_rdata = 32'h7777_0000;
    tick();
    bus.i_mem_rvalid = 1'b0;
    tick();
    tick();
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single unified memory port between the core's instruction-fetch requester and its data load/store requester, so an R32 core with split ROM/RAM ports can run from one single-ported memory. A round-robin FSM accepts one transaction at a time, drives the memory-side request/acknowledge/response handshake, routes the response back to the owning requester, and aborts any transaction the memory never answers with an error. It sits between the core top level and the memory/bus model.

## Interface
- TIMEOUT, default 255: maximum cycles spent in ISSUE+WAIT before abort (1..255; counter is 8 bits).
- i_clock  in  1  single clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_ins_req  in  1  fetch request; held with address until o_ins_grant seen.
- i_ins_address  in  32  fetch address.
- o_ins_grant  out  1  one-cycle pulse: fetch request accepted.
- o_ins_valid  out  1  one-cycle pulse: fetch complete.
- o_ins_data  out  32  fetched word; valid with o_ins_valid.
- o_ins_error  out  1  qualifies o_ins_valid: 1 = timed out.
- i_dat_req  in  1  data request; held with payload until o_dat_grant seen.
- i_dat_rw  in  1  1 = write, 0 = read.
- i_dat_address  in  32  data address.
- i_dat_wdata  in  32  write data.
- i_dat_strobe  in  4  byte-lane enables.
- o_dat_grant  out  1  one-cycle pulse: data request accepted.
- o_dat_valid  out  1  one-cycle pulse: data access complete.
- o_dat_rdata  out  32  read data; updated only on read completion.
- o_dat_error  out  1  qualifies o_dat_valid: 1 = timed out.
- o_mem_req  out  1  memory request; held until i_mem_ack.
- o_mem_rw, o_mem_address, o_mem_wdata, o_mem_strobe  out  1/32/32/4  latched transaction payload.
- i_mem_ack  in  1  memory accepted request.
- i_mem_rvalid  in  1  memory completed access (reads and writes).
- i_mem_rdata  in  32  read data, valid with i_mem_rvalid.
- o_timeout_flag  out  1  sticky: any timeout since reset.

## Operation
- States: IDLE, ISSUE, WAIT. One outstanding transaction.
- IDLE: at edge with any request, pick owner, latch payload into o_mem_* registers, set owner's grant for next cycle, counter := 0, go ISSUE. No request: stay.
- Arbitration: only one requesting → it wins. Both → the one not served last. Pointer last_served updates on each grant; reset value = instruction (data wins first tie).
- Fetch payload: o_mem_rw = 0, o_mem_strobe = 4'b1111, o_mem_wdata = 0.
- ISSUE: o_mem_req = 1. i_mem_ack high at edge → WAIT, o_mem_req = 0 next cycle.
- WAIT: i_mem_rvalid high at edge → owner's valid = 1 next cycle, error = 0; read: owner's data := i_mem_rdata; go IDLE.
- Counter increments each edge in ISSUE/WAIT. If counter == TIMEOUT - 1 at an edge without completing handshake → owner's valid = 1, error = 1, data output unchanged, o_timeout_flag := 1, o_mem_req = 0, go IDLE. Completion in the same edge as timeout wins (no error).
- i_mem_ack outside ISSUE, i_mem_rvalid outside WAIT: ignored. i_mem_ack and i_mem_rvalid in same ISSUE cycle: ack only; rvalid ignored.
- Requests arriving while not IDLE: not granted; requester keeps holding.

## Timing
- Reset: all outputs 0 (grants, valids, errors, o_mem_*, data outputs, o_timeout_flag), state IDLE, counter 0, last_served = instruction.
- Reset mid-transaction: transaction abandoned, no valid pulse, o_mem_req low the cycle after reset edge.
- Grant: request sampled at edge k → grant high cycle k→k+1; o_mem_req high from same cycle.
- Zero-wait memory (ack at k+1, rvalid at k+2): valid high cycle k+2→k+3; next arbitration at edge k+3. Max throughput 1 transaction / 3 cycles.
- Grant, valid, error are single-cycle pulses; error is 0 whenever valid is 0.

## Test plan
- Reset, single fetch at 0x0000_0010, memory acks next cycle, returns 0xDEAD_BEEF one cycle later → o_ins_grant one pulse, o_mem_rw=0, strobe=1111, o_ins_valid pulse with o_ins_data=0xDEAD_BEEF, error 0, 3 cycles request-to-valid-edge.
- Fetch and data read both asserted after reset, continuously re-requesting → grants alternate data, ins, data, ins; no requester granted twice in a row.
- Data write 0x1234_5678 to 0x100, strobe 0011, ack delayed 4 cycles, rvalid 2 cycles later → o_mem_req held 4 cycles with stable payload, o_dat_valid pulse, o_dat_rdata unchanged.
- TIMEOUT=8, memory never acks → o_dat_valid+o_dat_error pulse exactly 8 cycles after entering ISSUE, o_mem_req dropped, o_timeout_flag=1 and stays 1; following fetch completes normally.
- Stray i_mem_rvalid in IDLE and during ISSUE, ack+rvalid same cycle → no valid pulses; response only on later rvalid in WAIT.
- Assert i_reset during WAIT → no valid pulse, all outputs 0 next cycle, next tie grants data first.
